// File: rtl/lsic_irq_conditioner.sv
// Interrupt front-end for LSIC: per-line synchronizer, polarity fix, glitch filter
// and level/rising-edge conversion into clean registered active-high requests.
module lsic_irq_conditioner #(
    parameter int                 N_IRQ         = 64,
    parameter int                 SYNC_STAGES   = 2,
    parameter int                 FILTER_LEN    = 4,
    parameter logic [N_IRQ-1:0]   EDGE_MASK     = '0,
    parameter logic [N_IRQ-1:0]   POLARITY_MASK = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_raw,
    output logic [N_IRQ-1:0] irqs,
    output logic             irq_any
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0] s;
    logic [N_IRQ-1:0] f_vec;
    logic [N_IRQ-1:0] f_d;
    logic [N_IRQ-1:0] irqs_q;

    // Reset loads the inactive raw level so active-low lines never glitch on release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= POLARITY_MASK;
            end
        end else begin
            sync_q[0] <= irq_raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ POLARITY_MASK;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_line
        logic          f;
        logic [CW-1:0] cnt;

        // A change must persist FILTER_LEN consecutive cycles; any bounce restarts the count
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                f   <= 1'b0;
                cnt <= '0;
            end else if (s[i] == f) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                f   <= s[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign f_vec[i] = f;
    end

    // Edge lines mask out cycles where f was already high, leaving one pulse per rise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_d    <= '0;
            irqs_q <= '0;
        end else begin
            f_d    <= f_vec;
            irqs_q <= f_vec & ~(f_d & EDGE_MASK);
        end
    end

    assign irqs    = irqs_q;
    assign irq_any = |irqs_q;

endmodule

// File: tb/tb_lsic_irq_conditioner.sv
// Directed, table-driven bench for lsic_irq_conditioner: each record holds inputs
// for a run of cycles and the irqs value expected after every edge of that run.
module tb_lsic_irq_conditioner;

    localparam logic [63:0] B3   = 64'd1 << 3;
    localparam logic [63:0] B5   = 64'd1 << 5;
    localparam logic [63:0] B7   = 64'd1 << 7;
    localparam logic [63:0] B10  = 64'd1 << 10;
    localparam logic [63:0] B63  = 64'd1 << 63;
    localparam logic [63:0] R0   = B63;
    localparam logic [63:0] ALL  = ~64'd0;
    localparam logic [63:0] EDGES = B10 | B63;

    typedef struct {
        logic        rst_n;
        logic [63:0] raw;
        logic [63:0] exp;
        int          ncyc;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] irq_raw;
    logic [63:0] irqs;
    logic        irq_any;

    int   vec_count;
    int   miscompares;
    vec_t tbl[$];

    lsic_irq_conditioner #(
        .N_IRQ         (64),
        .SYNC_STAGES   (2),
        .FILTER_LEN    (4),
        .EDGE_MASK     (EDGES),
        .POLARITY_MASK (B63)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_raw (irq_raw),
        .irqs    (irqs),
        .irq_any (irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add_vec(logic r, logic [63:0] raw, logic [63:0] exp, int n);
        vec_t v;
        v.rst_n = r;
        v.raw   = raw;
        v.exp   = exp;
        v.ncyc  = n;
        tbl.push_back(v);
    endfunction

    task automatic applyStimulus(input logic r, input logic [63:0] raw);
        @(negedge clk);
        rst_n   = r;
        irq_raw = raw;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] exp);
        logic exp_any;
        exp_any = (exp != 64'd0);
        vec_count++;
        if (irqs !== exp || irq_any !== exp_any) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: irqs=%h irq_any=%b, want irqs=%h irq_any=%b",
                     name, $time, irqs, irq_any, exp, exp_any);
        end
    endtask

    initial begin
        int lat;
        vec_count   = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        irq_raw     = R0;

        // reset with active-low line 63 idle high, then idle
        add_vec(1'b0, R0, 64'd0, 5);
        add_vec(1'b1, R0, 64'd0, 20);
        // level line 3: assert, then deassert
        add_vec(1'b1, R0 | B3, 64'd0, 6);
        add_vec(1'b1, R0 | B3, B3, 10);
        add_vec(1'b1, R0, B3, 6);
        add_vec(1'b1, R0, 64'd0, 6);
        // line 5: 3-cycle glitch rejected
        add_vec(1'b1, R0 | B5, 64'd0, 3);
        add_vec(1'b1, R0, 64'd0, 12);
        // line 5: exactly 4-cycle pulse accepted for 4 cycles
        add_vec(1'b1, R0 | B5, 64'd0, 4);
        add_vec(1'b1, R0, 64'd0, 2);
        add_vec(1'b1, R0, B5, 4);
        add_vec(1'b1, R0, 64'd0, 6);
        // edge line 10: 30 high cycles give one pulse
        add_vec(1'b1, R0 | B10, 64'd0, 6);
        add_vec(1'b1, R0 | B10, B10, 1);
        add_vec(1'b1, R0 | B10, 64'd0, 23);
        // 4 low cycles, then high again: second pulse
        add_vec(1'b1, R0, 64'd0, 4);
        add_vec(1'b1, R0 | B10, 64'd0, 6);
        add_vec(1'b1, R0 | B10, B10, 1);
        add_vec(1'b1, R0 | B10, 64'd0, 8);
        add_vec(1'b1, R0, 64'd0, 10);
        // active-low edge line 63: 1->0 pulses, 0->1 silent
        add_vec(1'b1, 64'd0, 64'd0, 6);
        add_vec(1'b1, 64'd0, B63, 1);
        add_vec(1'b1, 64'd0, 64'd0, 10);
        add_vec(1'b1, R0, 64'd0, 16);
        // line 7 reset mid-qualification
        add_vec(1'b1, R0 | B7, 64'd0, 3);
        add_vec(1'b0, R0 | B7, 64'd0, 3);
        add_vec(1'b1, R0 | B7, 64'd0, 6);
        add_vec(1'b1, R0 | B7, B7, 5);
        add_vec(1'b1, R0, B7, 6);
        add_vec(1'b1, R0, 64'd0, 6);
        // every line asserted before the same edge
        add_vec(1'b1, ~R0, 64'd0, 6);
        add_vec(1'b1, ~R0, ALL, 1);
        add_vec(1'b1, ~R0, ~EDGES, 5);
        add_vec(1'b1, R0, ~EDGES, 6);
        add_vec(1'b1, R0, 64'd0, 6);

        for (int e = 0; e < tbl.size(); e++) begin
            for (int c = 0; c < tbl[e].ncyc; c++) begin
                applyStimulus(tbl[e].rst_n, tbl[e].raw);
                checkOutput($sformatf("tbl%0d.c%0d", e, c), tbl[e].exp);
            end
        end

        // hand sequence: measure line 3 assertion latency with a bounded wait
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, R0 | B3);
            if (irqs[3] === 1'b1 && lat < 0) lat = k;
        end
        vec_count++;
        if (lat != 6) begin
            miscompares++;
            $display("[TB] FAIL lat_rise: got %0d edges, want 6", lat);
        end
        checkOutput("lat_rise_hold", B3);

        // hand sequence: count pulses on edge line 10 over a long assertion
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b1, R0 | B3 | B10);
            if (irqs[10] === 1'b1) lat++;
        end
        vec_count++;
        if (lat != 1) begin
            miscompares++;
            $display("[TB] FAIL pulse_count10: got %0d pulses, want 1", lat);
        end
        checkOutput("both_held", B3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/lsic_irq_conditioner.md
# lsic_irq_conditioner

Front-end conditioner for the LSIC interrupt controller. It takes raw, asynchronous device interrupt lines and synchronizes each one into `clk`, applying per-line polarity, glitch filtering and edge/level conversion. It drives the LSIC `irqs` input with clean, registered, active-high requests. Edge-configured lines produce exactly one single-cycle pulse per qualified assertion, so the LSIC pending bit is set once and does not re-pend after the ISR clears it.

## Interface
Parameters:
- `N_IRQ`, 64: number of interrupt lines; must match LSIC `irqs` width.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth per line; legal range 2..4.
- `FILTER_LEN`, 4: consecutive cycles a changed synchronized level must hold before it is accepted; legal range 1..15.
- `EDGE_MASK`, 64'h0: bit i = 1 makes line i rising-edge (pulse) mode; 0 makes it level mode.
- `POLARITY_MASK`, 64'h0: bit i = 1 marks raw line i as active-low, inverted after synchronization.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `irq_raw`, in, N_IRQ: asynchronous device interrupt lines.
- `irqs`, out, N_IRQ: conditioned active-high requests to LSIC `irqs`, registered.
- `irq_any`, out, 1: OR-reduction of `irqs`.

## Operation
- Each line has an independent, identical pipeline: synchronizer, then polarity, then filter, then edge/level stage, then output register. Lines share nothing.
- **Synchronizer:** `SYNC_STAGES` flops. On reset every stage loads the line's inactive raw level (`POLARITY_MASK[i]`). As a result, an active-low line held high never produces a spurious assertion after reset.
- **Polarity:** `s = sync_out ^ POLARITY_MASK[i]`. After this point, 1 always means "asserted".
- **Filter state** per line: accepted level `f` (reset 0) and a counter `cnt` of `$clog2(FILTER_LEN+1)` bits (reset 0).
  - `s == f`: `cnt` is set to 0.
  - `s != f` and `cnt == FILTER_LEN-1`: `f` is set to `s` and `cnt` is set to 0.
  - `s != f` otherwise: `cnt` increments.
  - Any single-cycle return to `s == f` restarts qualification from zero.
  - With `FILTER_LEN = 1`, `f` follows `s` with one cycle of delay.
- **Level mode:** `irqs[i]` is the registered value of `f`. It stays high for as long as `f` is 1. LSIC re-pends the line after a clear while the device still asserts; this is intended level semantics.
- **Edge mode:** a previous-value flop `f_d` (reset 0) is kept. `irqs[i]` is set to `f & ~f_d` and is high for exactly one cycle per 0-to-1 transition of `f`. Deassertion produces no pulse.
- **`irq_any`:** combinational OR of the `irqs` register bits. It has no additional latency.
- **Reset:** all flops return to their reset values regardless of the state of any line mid-qualification. A partially counted `cnt` is discarded. Any pulse not yet emitted is lost.
- **Simultaneous events:** lines are independent, so any number of lines may assert in the same cycle. Each one appears in the same `irqs` cycle with no arbitration here; priority is LSIC's job.

## Timing
- Reset values: `irqs` = 0 and `irq_any` = 0 from the first edge with `rst_n` low until the first qualified assertion after release.
- Latency: let `irq_raw[i]` change and remain stable from before edge E0.
  - The `sync` output reflects the new value after edge E0+SYNC_STAGES-1.
  - `f` updates at edge E0+SYNC_STAGES+FILTER_LEN-1.
  - `irqs[i]` changes at edge E0+SYNC_STAGES+FILTER_LEN.
  - With default parameters, `irqs[i]` changes at E0+6.
- Deassertion latency in level mode is identical to assertion latency.
- Minimum accepted pulse width is `FILTER_LEN` cycles. Input pulses shorter than that are always rejected. Pulses of exactly `FILTER_LEN` cycles are accepted.
- Edge mode after a qualified rise:
  - A new pulse requires `f` to first return to 0, which needs `FILTER_LEN` low cycles.
  - It then needs another `FILTER_LEN` high cycles.
  - The minimum spacing between pulses is therefore 2×`FILTER_LEN` cycles.
- Inputs violating setup or hold at the first synchronizer stage may resolve either way. This shifts latency by at most one cycle and is never observed as a glitch on `irqs`.

## Test plan
All scenarios use default parameters unless stated.
- **Reset:** `irq_raw` = 0 with `POLARITY_MASK[63]` = 1 and `irq_raw[63]` = 1, reset held 5 cycles, then 20 idle cycles. Required: `irqs` = 0 and `irq_any` = 0 throughout.
- **Level line 3:** `irq_raw[3]` rises before edge E0 and is held. Required: `irqs[3]` = 1 from E0+6 and held, with `irq_any` = 1. When `irq_raw[3]` falls before edge E1, `irqs[3]` = 0 from E1+6.
- **Glitch filter on line 5:**
  - High for 3 cycles, then low. Required: `irqs[5]` never asserts.
  - High for exactly 4 cycles, then low. Required: `irqs[5]` = 1 from E0+6 for exactly 4 cycles.
- **Edge line 10 (`EDGE_MASK[10]` = 1):**
  - Raw held high for 30 cycles. Required: exactly one 1-cycle pulse at E0+6.
  - Low for 4 cycles, then high again. Required: a second single pulse.
- **Active-low edge line 63:** `irq_raw[63]` goes from 1 to 0. Required: one pulse on `irqs[63]` at E0+6. Returning to 1 produces no pulse.
- **Reset mid-qualification and simultaneity:**
  - `irq_raw[7]` goes high and `rst_n` is pulsed low 3 cycles later. Required: no assertion during reset. After release, `irqs[7]` asserts 6 edges after the first post-reset edge.
  - All 64 lines rise before the same edge. Required: all `irqs` bits assert in the same cycle.
